tcp_rx_key_cell_sched: RTL

Parametrised keyed descriptor-cell scheduler for the TOE TCP RX path. It replaces the fixed 4-beat, 8-worker table pre-request stage. The block accepts multi-beat descriptor cells, buffers them store-and-forward, and extracts a per-cell key (TCP flow id or MAC channel). It enforces a configurable minimum issue gap between cells with the same key before forwarding them to the table-request stage. It also supports a drain-on-exit mode.

---
 rtl/tcp_rx_key_sched_pkg.sv | 23 ++
 rtl/tcp_rx_key_hist.sv | 42 ++++
 rtl/tcp_rx_key_cell_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tcp_rx_key_sched_pkg.sv
// Shared types for the keyed TCP RX cell scheduler: FSM states, key-mode codes,
// history entry layout and the saturating age helper.
package tcp_rx_key_sched_pkg;

    typedef enum logic [1:0] {IDLE, CHK, SEND} state_t;

    localparam logic KEY_MODE_FID = 1'b0;
    localparam logic KEY_MODE_CHN = 1'b1;

    // History keys are stored zero-extended to this width so the struct is fixed.
    localparam int HIST_KEY_MAX = 64;

    typedef struct packed {
        logic                    vld;
        logic [HIST_KEY_MAX-1:0] key;
        logic [15:0]             age;
    } hist_ent_t;

    function automatic logic [15:0] age_inc(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

endpackage

// File: rtl/tcp_rx_key_hist.sv
// Issued-key history: shift register of {valid, key, age} with a parallel
// "same key issued too recently" compare against the candidate key.
module tcp_rx_key_hist
    import tcp_rx_key_sched_pkg::*;
#(
    parameter int HIST_NUM = 4,
    parameter int KEY_WID  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [KEY_WID-1:0] push_key,
    input  logic [KEY_WID-1:0] cmp_key,
    input  logic [15:0]        gap,
    output logic               hit
);

    hist_ent_t ent [HIST_NUM];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HIST_NUM; i++) ent[i] <= '0;
        end else if (push) begin
            ent[0] <= '{vld: 1'b1, key: HIST_KEY_MAX'(push_key), age: 16'd0};
            for (int i = 1; i < HIST_NUM; i++)
                ent[i] <= '{vld: ent[i-1].vld, key: ent[i-1].key, age: age_inc(ent[i-1].age)};
        end else begin
            for (int i = 0; i < HIST_NUM; i++) ent[i].age <= age_inc(ent[i].age);
        end
    end

    // An entry is written the cycle after its beat 0 and an eligible candidate
    // issues the cycle after the check, so beat-0 spacing is age + 2.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HIST_NUM; i++)
            if (ent[i].vld && ent[i].key == HIST_KEY_MAX'(cmp_key) &&
                (17'(ent[i].age) + 17'd2) < 17'(gap))
                hit = 1'b1;
    end

endmodule

// File: rtl/tcp_rx_key_cell_sched.sv
// Store-and-forward keyed cell scheduler with per-key minimum issue gap and drain-on-exit.
// Define TCP_RX_KEY_SCHED_STAT_EN to expose commit/stall/drain counters on dbg_sig.
module tcp_rx_key_cell_sched
    import tcp_rx_key_sched_pkg::*;
#(
    parameter int DWID     = 128,
    parameter int CELL_LEN = 4,
    parameter int DEPTH    = 8,
    parameter int KEY_WID  = 16,
    parameter int KEY_LSB  = 0,
    parameter int CHN_LSB  = 0,
    parameter int CHN_WID  = 4,
    parameter int HIST_NUM = 4,
    parameter int DBG_WID  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        cfg_gap,
    input  logic               cfg_key_mode,
    input  logic               flag_exit,
    output logic               exit_done,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DWID-1:0]    in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DWID-1:0]    out_dat,
    output logic [DBG_WID-1:0] dbg_sig
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              BW        = $clog2(CELL_LEN);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(CELL_LEN - 1);
    localparam logic [BW-1:0]   BEAT0     = '0;
    localparam logic [AW:0]     DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]     ONE_C     = (AW+1)'(1);

    logic [DWID-1:0]    ram     [DEPTH*CELL_LEN];
    logic [KEY_WID-1:0] key_mem [DEPTH];

    state_t             state;
    logic               live;
    logic [BW-1:0]      in_beat_cnt, out_beat;
    logic [AW-1:0]      wr_cell, rd_cell, nxt_cell;
    logic [AW:0]        cell_cnt;
    logic [KEY_WID-1:0] cur_key, in_key, cand_key, head_key;
    logic               in_hs, commit, out_hs, last_hs, pop, more, hist_hit, elig, chain, hist_push;

    assign in_hs     = in_vld && in_rdy;
    assign commit    = in_hs && in_beat_cnt == LAST_BEAT;
    assign out_hs    = out_vld && out_rdy;
    assign last_hs   = state == SEND && out_hs && out_beat == LAST_BEAT;
    assign pop       = last_hs;
    assign more      = cell_cnt > ONE_C;
    assign nxt_cell  = rd_cell + AW'(1);
    assign head_key  = key_mem[rd_cell];
    // During SEND the next cell is judged in parallel with the last beat.
    assign cand_key  = (state == SEND) ? key_mem[nxt_cell] : head_key;
    assign elig      = flag_exit || cfg_gap == 16'd0 || !hist_hit;
    assign chain     = more && elig;
    assign hist_push = state == SEND && out_hs && out_beat == BEAT0;

    assign in_rdy    = live && (in_beat_cnt != BEAT0 || (cell_cnt < DEPTH_C && !flag_exit));
    assign exit_done = live && flag_exit && cell_cnt == '0 && in_beat_cnt == BEAT0 && state == IDLE;

    always_comb begin
        in_key = '0;
        case (cfg_key_mode)
            KEY_MODE_FID: in_key = in_dat[KEY_LSB +: KEY_WID];
            KEY_MODE_CHN: in_key = KEY_WID'(in_dat[CHN_LSB +: CHN_WID]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_hs)  ram[{wr_cell, in_beat_cnt}] <= in_dat;
        if (commit) key_mem[wr_cell] <= cur_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live        <= 1'b0;
            in_beat_cnt <= '0;
            wr_cell     <= '0;
            cell_cnt    <= '0;
            cur_key     <= '0;
        end else begin
            live <= 1'b1;
            if (in_hs) in_beat_cnt <= in_beat_cnt + BW'(1);
            if (in_hs && in_beat_cnt == BEAT0) cur_key <= in_key;
            if (commit) wr_cell <= wr_cell + AW'(1);
            case ({commit, pop})
                2'b10:   cell_cnt <= cell_cnt + ONE_C;
                2'b01:   cell_cnt <= cell_cnt - ONE_C;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_beat <= '0;
            rd_cell  <= '0;
        end else begin
            case (state)
                IDLE: if (cell_cnt != '0 || commit) state <= CHK;
                CHK: begin
                    out_dat <= ram[{rd_cell, BEAT0}];
                    if (elig) begin
                        state    <= SEND;
                        out_vld  <= 1'b1;
                        out_beat <= '0;
                    end
                end
                SEND: if (out_hs) begin
                    if (out_beat != LAST_BEAT) begin
                        out_beat <= out_beat + BW'(1);
                        out_dat  <= ram[{rd_cell, out_beat + BW'(1)}];
                    end else begin
                        rd_cell  <= nxt_cell;
                        out_beat <= '0;
                        if (chain) begin
                            out_dat <= ram[{nxt_cell, BEAT0}];
                        end else begin
                            out_vld <= 1'b0;
                            state   <= more ? CHK : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tcp_rx_key_hist #(.HIST_NUM(HIST_NUM), .KEY_WID(KEY_WID)) u_hist (
        .clk      (clk),
        .rst      (rst),
        .push     (hist_push),
        .push_key (head_key),
        .cmp_key  (cand_key),
        .gap      (cfg_gap),
        .hit      (hist_hit)
    );

`ifdef TCP_RX_KEY_SCHED_STAT_EN
    logic        stall_evt;
    logic [15:0] st_commit;
    logic [7:0]  st_stall, st_drain;

    // A deferred beat 0 costs a cycle whether it waits in CHK or misses the chain slot.
    assign stall_evt = (state == CHK && !elig) || (last_hs && more && !elig);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_commit <= '0;
            st_stall  <= '0;
            st_drain  <= '0;
        end else begin
            if (commit) st_commit <= st_commit + 16'd1;
            if (stall_evt && st_stall != 8'hFF) st_stall <= st_stall + 8'd1;
            if (pop && flag_exit) st_drain <= st_drain + 8'd1;
        end
    end

    assign dbg_sig = DBG_WID'({st_drain, st_stall, st_commit});
`else
    assign dbg_sig = '0;
`endif

endmodule
